// File: rtl/motor_pos_sensor.sv
// motor_pos_sensor: position tracker for a motor driven up or down.
// Position moves one step every STEP_DIV cycles while a single command is
// held. It saturates at 0 and POS_MAX and stops automatically at either limit.
// Optional feature macro: POS_FAULT_EN. When it is defined, UP_M and DN_M
// asserted together latch a sticky FAULT state that only rst can clear.
module motor_pos_sensor #(
  parameter int POS_W    = 8,
  parameter int POS_MAX  = 200,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             UP_M,
  input  logic             DN_M,
  output logic             Up_Max,
  output logic             Dn_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUN_UP  = 2'd1;
  localparam logic [1:0] ST_RUN_DN  = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_TOP1 = POS_W'(POS_MAX - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PW-1:0]    presc_q, presc_d;

  // A command counts only when asserted alone; both high is never a move.
  logic up_cmd, dn_cmd, at_top, at_bot;
  assign up_cmd = UP_M & ~DN_M;
  assign dn_cmd = DN_M & ~UP_M;
  assign at_top = (pos_q == POS_TOP);
  assign at_bot = (pos_q == '0);

  // Next-state, position and prescaler logic
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    case (state_q)
      ST_STOPPED: begin
        presc_d = '0;
        if (up_cmd && !at_top)      state_d = ST_RUN_UP;
        else if (dn_cmd && !at_bot) state_d = ST_RUN_DN;
      end
      ST_RUN_UP: begin
        if (up_cmd && !at_top) begin
          if (presc_q == PRE_LAST) begin
            presc_d = '0;
            pos_d   = pos_q + POS_ONE;
            // Stop on the same edge that lands on the top limit.
            if (pos_q == POS_TOP1) state_d = ST_STOPPED;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end else begin
          // Drop or reversal: park in STOPPED, reversal re-enters from there.
          state_d = ST_STOPPED;
          presc_d = '0;
        end
      end
      ST_RUN_DN: begin
        if (dn_cmd && !at_bot) begin
          if (presc_q == PRE_LAST) begin
            presc_d = '0;
            pos_d   = pos_q - POS_ONE;
            if (pos_q == POS_ONE) state_d = ST_STOPPED;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end else begin
          state_d = ST_STOPPED;
          presc_d = '0;
        end
      end
      ST_FAULT: begin
        presc_d = '0;
      end
      default: begin
        state_d = ST_STOPPED;
        presc_d = '0;
      end
    endcase
`ifdef POS_FAULT_EN
    // Conflicting commands override everything else and hold the position.
    if (UP_M && DN_M) begin
      state_d = ST_FAULT;
      pos_d   = pos_q;
      presc_d = '0;
    end
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOPPED;
      pos_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
    end
  end

  assign Position = pos_q;
  assign Up_Max   = at_top;
  assign Dn_Max   = at_bot;
  assign Moving   = (state_q == ST_RUN_UP) || (state_q == ST_RUN_DN);
`ifdef POS_FAULT_EN
  assign Fault    = (state_q == ST_FAULT);
`else
  assign Fault    = 1'b0;
`endif

endmodule
